// File: rtl/lcg_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : lcg_stim_gen
// Description : Seeded, replayable stimulus source. A 32-bit LCG fills a
//               WIDTH-bit word one 32-bit chunk per clock; each completed
//               word is offered on a valid/ready handshake. A run emits a
//               programmed number of words and then parks in DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module lcg_stim_gen #(
  parameter int WIDTH = 132,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [31:0]      seed,
  input  logic             start,
  input  logic [CNT_W-1:0] cycles,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] word_count
);

  // Number of 32-bit chunks per word and the width of the chunk index.
  localparam int NCH  = (WIDTH + 31) / 32;
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [CH_W-1:0] LAST_CHUNK = CH_W'(NCH - 1);
  localparam logic [31:0]     LCG_MUL    = 32'h41C6_4E6D;
  localparam logic [31:0]     LCG_INC    = 32'h0000_3039;

  // One 32-bit lane aligned at bit 0; shifted up to the active chunk. For the
  // last chunk the upper lane bits fall off the top, so only the remaining
  // WIDTH-32*(NCH-1) LSBs are written.
  localparam logic [WIDTH-1:0] LANE_MASK = WIDTH'(32'hFFFF_FFFF);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       rng_q, rng_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [CH_W-1:0]   chunk_q, chunk_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic              valid_q, valid_d;

  logic [31:0]       w_lcg_next;
  logic [WIDTH-1:0]  w_lane_data;
  logic [WIDTH-1:0]  w_lane_mask;
  logic [CH_W+4:0]   w_lane_shift;
  logic [CNT_W-1:0]  w_count_inc;

  // Next LCG value; the multiply is naturally truncated to 32 bits (mod 2^32).
  assign w_lcg_next = rng_q * LCG_MUL + LCG_INC;

  // The LCG value replicated across every chunk position, so the masked merge
  // below only needs a shifted mask rather than a shifted data path.
  for (genvar b = 0; b < WIDTH; b++) begin : g_lane
    assign w_lane_data[b] = w_lcg_next[b % 32];
  end

  assign w_lane_shift = {chunk_q, 5'b00000};
  assign w_lane_mask  = LANE_MASK << w_lane_shift;
  assign w_count_inc  = count_q + CNT_W'(1);

  // State and datapath registers; asynchronous reset clears everything,
  // including the generator state, so a new run must reload the seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rng_q    <= '0;
      data_q   <= '0;
      chunk_q  <= '0;
      count_q  <= '0;
      cycles_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rng_q    <= rng_d;
      data_q   <= data_d;
      chunk_q  <= chunk_d;
      count_q  <= count_d;
      cycles_q <= cycles_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state and datapath update; every register holds unless told otherwise.
  always_comb begin
    state_d  = state_q;
    rng_d    = rng_q;
    data_d   = data_q;
    chunk_d  = chunk_q;
    count_d  = count_q;
    cycles_d = cycles_q;
    valid_d  = valid_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // seed_load is evaluated first so a same-cycle start uses the new seed.
        if (seed_load) begin
          rng_d   = seed;
          state_d = ST_IDLE;
        end
        if (start) begin
          count_d  = '0;
          chunk_d  = '0;
          cycles_d = cycles;
          state_d  = (cycles == '0) ? ST_DONE : ST_FILL;
        end
      end

      ST_FILL: begin
        rng_d  = w_lcg_next;
        data_d = (data_q & ~w_lane_mask) | (w_lane_data & w_lane_mask);
        if (chunk_q == LAST_CHUNK) begin
          chunk_d = '0;
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end else begin
          chunk_d = chunk_q + CH_W'(1);
        end
      end

      ST_PRESENT: begin
        // Word and valid hold steady until the consumer takes the word.
        if (out_ready) begin
          count_d = w_count_inc;
          valid_d = 1'b0;
          chunk_d = '0;
          state_d = (w_count_inc == cycles_q) ? ST_DONE : ST_FILL;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign busy       = (state_q == ST_FILL) || (state_q == ST_PRESENT);
  assign done       = (state_q == ST_DONE);
  assign word_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_lcg_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcg_stim_gen
// Description : Directed self-checking bench for lcg_stim_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcg_stim_gen;

  localparam int WIDTH  = 132;
  localparam int CNT_W  = 16;
  localparam int NCH    = 5;
  localparam int LAST_W = WIDTH - 32 * (NCH - 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             seed_load = 1'b0;
  logic [31:0]      seed = '0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] cycles = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] word_count;

  int total = 0;
  int bad   = 0;

  logic [31:0]      m_rng;
  logic [WIDTH-1:0] w_hold;

  always #5 clk = ~clk;

  lcg_stim_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_load  (seed_load),
    .seed       (seed),
    .start      (start),
    .cycles     (cycles),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
  );

  function automatic logic [31:0] lcg(input logic [31:0] x);
    return x * 32'h41C6_4E6D + 32'h0000_3039;
  endfunction

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle before driving/sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference word: NCH consecutive LCG outputs, last one truncated.
  task automatic model_word(output logic [WIDTH-1:0] w);
    w = '0;
    for (int k = 0; k < NCH; k++) begin
      m_rng = lcg(m_rng);
      if (k == NCH - 1) w[32*k +: LAST_W] = m_rng[LAST_W-1:0];
      else              w[32*k +: 32]     = m_rng;
    end
  endtask

  task automatic expect_word(input string tag);
    logic [WIDTH-1:0] w;
    model_word(w);
    check(tag, out_data, w);
  endtask

  // Bounded wait for out_valid; an expired budget shows up as a failed check.
  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check(tag, WIDTH'(out_valid), WIDTH'(1));
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_valid", WIDTH'(out_valid), '0);
    check("rst_data", out_data, '0);
    check("rst_busy", WIDTH'(busy), '0);
    check("rst_done", WIDTH'(done), '0);
    check("rst_wc", WIDTH'(word_count), '0);
    rst = 1'b0;

    // ---------------- single word, seed 0 ----------------
    out_ready = 1'b1;
    seed = 32'h0; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    start = 1'b1; cycles = 16'd1;
    tick();
    start = 1'b0;
    check("t1_busy", WIDTH'(busy), WIDTH'(1));
    repeat (4) tick();
    check("t1_fill_not_valid", WIDTH'(out_valid), '0);
    tick();
    check("t1_valid_lat5", WIDTH'(out_valid), WIDTH'(1));
    check("t1_chunk0", WIDTH'(out_data[31:0]), WIDTH'(32'h0000_3039));
    check("t1_chunk1", WIDTH'(out_data[63:32]), WIDTH'(32'hD3DC_167E));
    m_rng = 32'h0;
    expect_word("t1_word");
    tick();
    check("t1_done", WIDTH'(done), WIDTH'(1));
    check("t1_wc", WIDTH'(word_count), WIDTH'(1));
    check("t1_busy_end", WIDTH'(busy), '0);
    check("t1_valid_end", WIDTH'(out_valid), '0);

    // ---------------- back-pressure, 3 words ----------------
    out_ready = 1'b0;
    seed = 32'h0; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("t2_seedload_clears_done", WIDTH'(done), '0);
    start = 1'b1; cycles = 16'd3;
    tick();
    start = 1'b0;
    m_rng = 32'h0;
    wait_valid("t2_w0_valid");
    expect_word("t2_w0");
    w_hold = out_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t2_stall_valid", WIDTH'(out_valid), WIDTH'(1));
      check("t2_stall_data", out_data, w_hold);
    end
    check("t2_stall_wc", WIDTH'(word_count), '0);
    out_ready = 1'b1;
    tick();
    check("t2_wc_after_w0", WIDTH'(word_count), WIDTH'(1));
    wait_valid("t2_w1_valid");
    expect_word("t2_w1");
    tick();
    wait_valid("t2_w2_valid");
    expect_word("t2_w2");
    tick();
    check("t2_done", WIDTH'(done), WIDTH'(1));
    check("t2_wc", WIDTH'(word_count), WIDTH'(3));

    // ---------------- zero-length run ----------------
    start = 1'b1; cycles = 16'd0;
    tick();
    start = 1'b0;
    check("t3_done", WIDTH'(done), WIDTH'(1));
    check("t3_busy", WIDTH'(busy), '0);
    check("t3_wc", WIDTH'(word_count), '0);
    repeat (3) tick();
    check("t3_no_valid", WIDTH'(out_valid), '0);
    check("t3_still_done", WIDTH'(done), WIDTH'(1));

    // ---------------- async reset mid-fill of word 2 ----------------
    seed = 32'h0; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    start = 1'b1; cycles = 16'd5;
    tick();
    start = 1'b0;
    m_rng = 32'h0;
    wait_valid("t4_w0_valid");
    expect_word("t4_w0");
    tick();
    wait_valid("t4_w1_valid");
    expect_word("t4_w1");
    tick();
    tick();
    #3 rst = 1'b1;
    #1;
    check("t4_rst_valid", WIDTH'(out_valid), '0);
    check("t4_rst_data", out_data, '0);
    check("t4_rst_busy", WIDTH'(busy), '0);
    check("t4_rst_done", WIDTH'(done), '0);
    check("t4_rst_wc", WIDTH'(word_count), '0);
    rst = 1'b0;
    tick();
    seed = 32'h0; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    start = 1'b1; cycles = 16'd1;
    tick();
    start = 1'b0;
    m_rng = 32'h0;
    wait_valid("t4_re_valid");
    check("t4_re_chunk0", WIDTH'(out_data[31:0]), WIDTH'(32'h0000_3039));
    expect_word("t4_re_word");
    tick();
    check("t4_re_done", WIDTH'(done), WIDTH'(1));

    // ---------------- start/seed_load while busy ----------------
    seed = 32'h0; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    start = 1'b1; cycles = 16'd2;
    tick();
    start = 1'b0;
    m_rng = 32'h0;
    tick();
    seed = 32'hFFFF_FFFF; seed_load = 1'b1; start = 1'b1; cycles = 16'd0;
    tick();
    seed_load = 1'b0; start = 1'b0;
    wait_valid("t5_w0_valid");
    expect_word("t5_w0");
    seed_load = 1'b1; start = 1'b1;
    tick();
    seed_load = 1'b0; start = 1'b0;
    check("t5_busy_after_ignored", WIDTH'(busy), WIDTH'(1));
    wait_valid("t5_w1_valid");
    expect_word("t5_w1");
    tick();
    check("t5_done", WIDTH'(done), WIDTH'(1));
    check("t5_wc", WIDTH'(word_count), WIDTH'(2));

    // ---------------- seed_load + start together from DONE ----------------
    seed = 32'h0; seed_load = 1'b1; start = 1'b1; cycles = 16'd1;
    tick();
    seed_load = 1'b0; start = 1'b0;
    check("t6_done_drop", WIDTH'(done), '0);
    check("t6_busy", WIDTH'(busy), WIDTH'(1));
    m_rng = 32'h0;
    wait_valid("t6_valid");
    check("t6_chunk0", WIDTH'(out_data[31:0]), WIDTH'(32'h0000_3039));
    expect_word("t6_word");
    tick();
    check("t6_done", WIDTH'(done), WIDTH'(1));
    check("t6_wc", WIDTH'(word_count), WIDTH'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
